// File: rtl/hzdunit_pkg.sv
// Shared pipeline definitions for the hazard unit: opcodes, shadow entry, FSM states.
package hzdunit_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned PERF_W = 32;

    // instr[6:2] opcode values
    localparam logic [OPC_W-1:0] OP_LOAD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_STORE  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_BRANCH = 5'b11000;
    localparam logic [OPC_W-1:0] OP_JAL    = 5'b11011;
    localparam logic [OPC_W-1:0] OP_JALR   = 5'b11001;
    localparam logic [OPC_W-1:0] OP_LUI    = 5'b01101;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OP     = 5'b01100;
    localparam logic [OPC_W-1:0] OP_FENCE  = 5'b00011;

    typedef struct packed {
        logic              v;
        logic              ld;
        logic              wen;
        logic [REG_AW-1:0] rd;
    } shadow_t;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hzd_state_e;

    // Source/destination match; x0 never creates a dependency
    function automatic logic raw_hit(input logic use_rs, input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rd);
        return use_rs && (rs == rd) && (rd != REG_AW'(0));
    endfunction

endpackage

// File: rtl/hzdunit_srcdecode.sv
// Register-usage decode of the ID-stage instruction for hazard detection.
module srcdecode
    import hzdunit_pkg::*;
(
    input  logic [XLEN-1:0]   instr,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd,
    output logic              use_rs1,
    output logic              use_rs2,
    output logic              is_load,
    output logic              wen
);

    logic [OPC_W-1:0] opc;
    logic             unused_bits;

    assign opc = instr[6:2];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];

    assign use_rs1 = !((opc == OP_LUI) || (opc == OP_AUIPC) || (opc == OP_JAL));
    assign use_rs2 = (opc == OP_OP) || (opc == OP_STORE) || (opc == OP_BRANCH);
    assign is_load = (opc == OP_LOAD);
    assign wen     = !((opc == OP_STORE) || (opc == OP_BRANCH) || (opc == OP_FENCE));

    // funct/imm/size bits play no part in hazard decisions
    assign unused_bits = ^{instr[31:25], instr[14:12], instr[1:0]};

endmodule

// File: rtl/hzdunit.sv
// Load-use / redirect / dmem-wait hazard control for the 5-stage pipe.
// Optional HZD_PERF_EN adds per-condition 32-bit cycle counters.
module hzdunit
    import hzdunit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr_id,
    input  logic            valid_id,
    input  logic            redirect_ex,
    input  logic            dmem_wait,
    output logic            stall_pc,
    output logic            stall_ifid,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            freeze,
    output logic            ldpend
`ifdef HZD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_ldstall,
    output logic [PERF_W-1:0] perf_flush,
    output logic [PERF_W-1:0] perf_wait
`endif
);

    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              use_rs1, use_rs2, is_load, wen;

    shadow_t    ex_q, mem_q, id_info_c;
    hzd_state_e state_q, state_d;
    logic       ld_use_c, act_wait_c, act_flush_c, act_ld_c;

    srcdecode u_srcdecode (
        .instr   (instr_id),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .is_load (is_load),
        .wen     (wen)
    );

    assign ld_use_c = ex_q.v && ex_q.ld && valid_id &&
                      (raw_hit(use_rs1, rs1, ex_q.rd) || raw_hit(use_rs2, rs2, ex_q.rd));

    // Single priority resolution: dmem wait > redirect > load-use
    assign act_wait_c  = dmem_wait;
    assign act_flush_c = !dmem_wait && redirect_ex;
    assign act_ld_c    = !dmem_wait && !redirect_ex && ld_use_c;

    always_comb begin
        state_d    = state_q;
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        freeze     = 1'b0;
        ldpend     = ex_q.v && ex_q.ld;

        unique case (state_q)
            RUN:     if (dmem_wait)  state_d = WAIT;
            WAIT:    if (!dmem_wait) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (act_wait_c) begin
            freeze     = 1'b1;
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
        end else if (act_flush_c) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (act_ld_c) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
        end

        id_info_c = '{v: valid_id && !flush_idex, ld: is_load, wen: wen, rd: rd};
    end

    // Shadow of the ID/EX and EX/MEM destinations; holds while memory stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ex_q    <= '0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            if (!dmem_wait) begin
                mem_q <= ex_q;
                ex_q  <= id_info_c;
            end
        end
    end

`ifdef HZD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ldstall <= '0;
            perf_flush   <= '0;
            perf_wait    <= '0;
        end else begin
            if (act_ld_c)    perf_ldstall <= perf_ldstall + PERF_W'(1);
            if (act_flush_c) perf_flush   <= perf_flush + PERF_W'(1);
            if (act_wait_c)  perf_wait    <= perf_wait + PERF_W'(1);
        end
    end
`endif

    a_wait_tracks: assert property (@(posedge clk) (state_q == WAIT) |-> $past(dmem_wait));

    a_freeze_holds: assert property (@(posedge clk)
        (!rst && dmem_wait) |=> (ex_q == $past(ex_q)) && (mem_q == $past(mem_q)));

    // After a load-use stall the load sits in MEM and a bubble in EX
    a_ld_advance: assert property (@(posedge clk)
        (!rst && act_ld_c) |=> (mem_q.v && mem_q.ld && !ex_q.v));

endmodule

// File: tb/tb_hzdunit.sv
// Scoreboard bench for hzdunit: per-cycle expected control vectors queued at drive time.
module tb_hzdunit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_id = '0;
    logic        valid_id = 1'b0;
    logic        redirect_ex = 1'b0;
    logic        dmem_wait = 1'b0;
    logic        stall_pc, stall_ifid, flush_ifid, flush_idex, freeze, ldpend;
`ifdef HZD_PERF_EN
    logic [31:0] perf_ldstall, perf_flush, perf_wait;
`endif

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q[$];
    string      name_q[$];

    // {stall_pc, stall_ifid, flush_ifid, flush_idex, freeze, ldpend}
    localparam logic [5:0] E_NONE       = 6'b000000;
    localparam logic [5:0] E_LDP        = 6'b000001;
    localparam logic [5:0] E_STALL      = 6'b110101;
    localparam logic [5:0] E_FLUSH      = 6'b001100;
    localparam logic [5:0] E_FLUSH_LDP  = 6'b001101;
    localparam logic [5:0] E_FREEZE     = 6'b110010;
    localparam logic [5:0] E_FREEZE_LDP = 6'b110011;

    always #5 clk = ~clk;

    hzdunit dut (
        .clk         (clk),
        .rst         (rst),
        .instr_id    (instr_id),
        .valid_id    (valid_id),
        .redirect_ex (redirect_ex),
        .dmem_wait   (dmem_wait),
        .stall_pc    (stall_pc),
        .stall_ifid  (stall_ifid),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .freeze      (freeze),
        .ldpend      (ldpend)
`ifdef HZD_PERF_EN
        ,
        .perf_ldstall (perf_ldstall),
        .perf_flush   (perf_flush),
        .perf_wait    (perf_wait)
`endif
    );

    function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
        return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_lw(input int rd, input int rs1);
        return {12'h004, 5'(rs1), 3'b010, 5'(rd), 7'h03};
    endfunction

    function automatic logic [31:0] enc_sw(input int rs1, input int rs2);
        return {7'h00, 5'(rs2), 5'(rs1), 3'b010, 5'h08, 7'h23};
    endfunction

    function automatic logic [31:0] enc_lui(input int rd);
        return {20'h12345, 5'(rd), 7'h37};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected during that cycle
    task automatic step(input logic [31:0] ins, input logic v, input logic r, input logic w,
                        input logic rs, input logic [5:0] e, input string nm);
        @(posedge clk);
        #1;
        instr_id    = ins;
        valid_id    = v;
        redirect_ex = r;
        dmem_wait   = w;
        rst         = rs;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    // Scoreboard: compare the queued expectation against the live outputs mid-cycle
    always @(negedge clk) begin
        logic [5:0] obs, e;
        string      nm;
        if (exp_q.size() != 0) begin
            obs = {stall_pc, stall_ifid, flush_ifid, flush_idex, freeze, ldpend};
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b (sp,si,fi,fx,fz,lp)", nm, obs, e);
            end
        end
    end

    task automatic test_reset();
        logic [5:0] obs;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = {stall_pc, stall_ifid, flush_ifid, flush_idex, freeze, ldpend};
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000", obs);
        end
`ifdef HZD_PERF_EN
        checks++;
        if ({perf_ldstall, perf_flush, perf_wait} !== 96'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d/%0d/%0d expected 0/0/0",
                     perf_ldstall, perf_flush, perf_wait);
        end
`endif
        step('0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "post_reset_idle");
    endtask

    task automatic test_load_use();
        step(enc_lw(5, 1),    1'b1, 1'b0, 1'b0, 1'b0, E_NONE,  "lu_issue");
        step(enc_r(6, 5, 7),  1'b1, 1'b0, 1'b0, 1'b0, E_STALL, "lu_stall");
        step(enc_r(6, 5, 7),  1'b1, 1'b0, 1'b0, 1'b0, E_NONE,  "lu_release");
        step('0,              1'b0, 1'b0, 1'b0, 1'b0, E_NONE,  "lu_idle");
        step(enc_lw(5, 1),    1'b1, 1'b0, 1'b0, 1'b0, E_NONE,  "st_issue");
        step(enc_sw(2, 5),    1'b1, 1'b0, 1'b0, 1'b0, E_STALL, "st_rs2_stall");
        step(enc_sw(2, 5),    1'b1, 1'b0, 1'b0, 1'b0, E_NONE,  "st_release");
        step('0,              1'b0, 1'b0, 1'b0, 1'b0, E_NONE,  "st_idle");
    endtask

    task automatic test_no_hazard();
        step(enc_lw(0, 1),    1'b1, 1'b0, 1'b0, 1'b0, E_NONE, "x0_issue");
        step(enc_r(1, 0, 0),  1'b1, 1'b0, 1'b0, 1'b0, E_LDP,  "x0_no_stall");
        step(enc_lw(5, 1),    1'b1, 1'b0, 1'b0, 1'b0, E_NONE, "lui_issue");
        step(enc_lui(5),      1'b1, 1'b0, 1'b0, 1'b0, E_LDP,  "lui_no_stall");
        step(enc_lw(5, 1),    1'b1, 1'b0, 1'b0, 1'b0, E_NONE, "unrel_issue");
        step(enc_r(6, 7, 8),  1'b1, 1'b0, 1'b0, 1'b0, E_LDP,  "unrel_no_stall");
        step(enc_lw(5, 1),    1'b1, 1'b0, 1'b0, 1'b0, E_NONE, "bubble_issue");
        step(enc_r(6, 5, 7),  1'b0, 1'b0, 1'b0, 1'b0, E_LDP,  "bubble_no_stall");
        step('0,              1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "nh_idle");
    endtask

    task automatic test_redirect();
        step(enc_lw(5, 1),    1'b1, 1'b0, 1'b0, 1'b0, E_NONE,      "rd_issue");
        step(enc_r(6, 5, 7),  1'b1, 1'b1, 1'b0, 1'b0, E_FLUSH_LDP, "rd_over_lu");
        step(enc_r(6, 5, 7),  1'b1, 1'b1, 1'b0, 1'b0, E_FLUSH,     "rd_plain");
        step('0,              1'b0, 1'b0, 1'b0, 1'b0, E_NONE,      "rd_idle");
    endtask

    task automatic test_dmem_wait();
        step(enc_lw(5, 1), 1'b1, 1'b0, 1'b0, 1'b0, E_NONE, "dw_issue");
        for (int i = 0; i < 3; i++)
            step(enc_r(6, 5, 7), 1'b1, 1'b1, 1'b1, 1'b0, E_FREEZE_LDP, $sformatf("dw_freeze%0d", i));
        step(enc_r(6, 5, 7), 1'b1, 1'b1, 1'b0, 1'b0, E_FLUSH_LDP, "dw_flush_after");
        step('0,             1'b0, 1'b0, 1'b0, 1'b0, E_NONE,      "dw_idle");
    endtask

    task automatic test_back_to_back();
        step(enc_lw(5, 1),   1'b1, 1'b0, 1'b0, 1'b0, E_NONE,  "b2b_lw5");
        step(enc_lw(6, 5),   1'b1, 1'b0, 1'b0, 1'b0, E_STALL, "b2b_stall1");
        step(enc_lw(6, 5),   1'b1, 1'b0, 1'b0, 1'b0, E_NONE,  "b2b_release1");
        step(enc_r(7, 6, 0), 1'b1, 1'b0, 1'b0, 1'b0, E_STALL, "b2b_stall2");
        step(enc_r(7, 6, 0), 1'b1, 1'b0, 1'b0, 1'b0, E_NONE,  "b2b_release2");
        step('0,             1'b0, 1'b0, 1'b0, 1'b0, E_NONE,  "b2b_idle");
    endtask

    task automatic test_reset_mid_stall();
        step(enc_lw(5, 1),   1'b1, 1'b0, 1'b0, 1'b0, E_NONE,  "rms_issue");
        step(enc_r(6, 5, 7), 1'b1, 1'b0, 1'b0, 1'b1, E_STALL, "rms_stall_in_reset");
        step(enc_r(6, 5, 7), 1'b1, 1'b0, 1'b0, 1'b0, E_NONE,  "rms_after_reset");
`ifdef HZD_PERF_EN
        checks++;
        if ({perf_ldstall, perf_flush, perf_wait} !== 96'd0) begin
            errors++;
            $display("FAIL rms_perf: got %0d/%0d/%0d expected 0/0/0",
                     perf_ldstall, perf_flush, perf_wait);
        end
`endif
        step('0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "rms_idle");
    endtask

`ifdef HZD_PERF_EN
    task automatic test_perf();
        step('0,             1'b0, 1'b0, 1'b0, 1'b1, E_NONE,   "pf_reset");
        step(enc_lw(5, 1),   1'b1, 1'b0, 1'b0, 1'b0, E_NONE,   "pf_issue");
        step(enc_r(6, 5, 7), 1'b1, 1'b0, 1'b0, 1'b0, E_STALL,  "pf_stall");
        step(enc_r(6, 5, 7), 1'b1, 1'b0, 1'b0, 1'b0, E_NONE,   "pf_release");
        step('0,             1'b0, 1'b1, 1'b0, 1'b0, E_FLUSH,  "pf_flush");
        step('0,             1'b0, 1'b0, 1'b1, 1'b0, E_FREEZE, "pf_wait0");
        step('0,             1'b0, 1'b0, 1'b1, 1'b0, E_FREEZE, "pf_wait1");
        step('0,             1'b0, 1'b0, 1'b0, 1'b0, E_NONE,   "pf_idle");
        checks++;
        if (perf_ldstall !== 32'd1 || perf_flush !== 32'd1 || perf_wait !== 32'd2) begin
            errors++;
            $display("FAIL perf_counts: got %0d/%0d/%0d expected 1/1/2",
                     perf_ldstall, perf_flush, perf_wait);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_redirect();
        test_dmem_wait();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef HZD_PERF_EN
        test_perf();
`endif
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
